sipo_deserializer: RTL and testbench

Serial-in, parallel-out receiver: the opposite end of the team's PISO shift-register link. It samples one serial bit per enabled clock and assembles `WIDTH` bits into a word. Each completed word is presented on a valid/ready output port with a one-word holding register and a sticky overrun flag. The block sits on the receive side of the serial link, between the line and the consuming datapath.

---
 rtl/sipo_deserializer.sv | 85 ++++++++
 tb/tb_sipo_deserializer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: assembles WIDTH line bits into a word and
// presents it through a one-entry valid/ready holding register with sticky overrun.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             complete, slot_free;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign sr_shift = {sr_q[WIDTH-2:0], sin};
        end else begin : g_lsb
            assign sr_shift = {sin, sr_q[WIDTH-1:1]};
        end
    endgenerate

    // A bit presented together with clear is discarded, so it never completes a word.
    assign complete  = sin_en && !clear && (cnt_q == CW'(WIDTH - 1));
    assign slot_free = !valid_q || dout_ready;

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (clear) begin
            sr_d  = '0;
            cnt_d = '0;
            ovr_d = 1'b0;
        end else if (sin_en) begin
            sr_d  = sr_shift;
            cnt_d = (cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + CW'(1);
        end

        // Holding register: a completion refills it in the same cycle it is consumed.
        if (complete && slot_free) begin
            dout_d  = sr_shift;
            valid_d = 1'b1;
        end else begin
            if (valid_q && dout_ready) valid_d = 1'b0;
            if (complete)              ovr_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overrun    = ovr_q;
    assign busy       = (cnt_q != '0);
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: MSB-first and LSB-first instances share
// stimulus; expected words are queued when sent and popped when presented.
module tb_sipo_deserializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sin = 1'b0, sin_en = 1'b0, clear = 1'b0, dout_ready = 1'b0;
    logic [3:0] dout_m, dout_l;
    logic       valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

    int errors = 0;
    int checks = 0;
    logic [3:0] q_m[$];
    logic [3:0] q_l[$];

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1)) u_m (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .clear(clear),
        .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
        .busy(busy_m), .overrun(ovr_m));

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(0)) u_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .clear(clear),
        .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
        .busy(busy_l), .overrun(ovr_l));

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pop_m(input string tag);
        logic [3:0] e;
        if (q_m.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, dout_m);
        end else begin
            e = q_m.pop_front();
            chk_w(tag, dout_m, e);
        end
    endtask

    task automatic pop_l(input string tag);
        logic [3:0] e;
        if (q_l.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, dout_l);
        end else begin
            e = q_l.pop_front();
            chk_w(tag, dout_l, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sbit(input logic b);
        sin = b; sin_en = 1'b1;
        tick();
        sin_en = 1'b0; sin = 1'b0;
    endtask

    // Bits given in line order; MSB-first word has bit0 of the line in [3].
    task automatic send4(input logic [3:0] line);
        for (int i = 0; i < 4; i++) sbit(line[3-i]);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        #3;
        chk_w("rst_dout", dout_m, 4'b0000);
        chk_b("rst_valid", valid_m, 1'b0);
        chk_b("rst_busy", busy_m, 1'b0);
        chk_b("rst_ovr", ovr_m, 1'b0);
        tick();
        rst = 1'b1;

        // 1: MSB-first 0,1,1,1
        sbit(1'b0); chk_b("t1_busy1", busy_m, 1'b1);
        sbit(1'b1); chk_b("t1_busy2", busy_m, 1'b1);
        sbit(1'b1); chk_b("t1_busy3", busy_m, 1'b1);
        chk_b("t1_valid3", valid_m, 1'b0);
        q_m.push_back(4'b0111);
        sbit(1'b1);
        chk_b("t1_busy4", busy_m, 1'b0);
        chk_b("t1_valid", valid_m, 1'b1);
        pop_m("t1_dout");

        // 2: LSB-first 1,0,0,0 with a 2-cycle gap
        do_reset();
        sbit(1'b1); sbit(1'b0);
        tick(); tick();
        chk_b("t2_busy_gap", busy_l, 1'b1);
        chk_b("t2_valid_gap", valid_l, 1'b0);
        sbit(1'b0);
        chk_b("t2_valid3", valid_l, 1'b0);
        q_l.push_back(4'b0001);
        sbit(1'b0);
        chk_b("t2_valid", valid_l, 1'b1);
        pop_l("t2_dout");

        // 3: overrun
        do_reset();
        q_m.push_back(4'b1111);
        send4(4'b1111);
        pop_m("t3_dout1");
        send4(4'b1010);
        chk_w("t3_dout_held", dout_m, 4'b1111);
        chk_b("t3_ovr", ovr_m, 1'b1);
        chk_b("t3_valid", valid_m, 1'b1);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        chk_b("t3_valid_hs", valid_m, 1'b0);
        chk_b("t3_ovr_sticky", ovr_m, 1'b1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk_b("t3_ovr_clear", ovr_m, 1'b0);

        // 4: consume and complete in the same cycle
        do_reset();
        q_m.push_back(4'b0011);
        send4(4'b0011);
        pop_m("t4_dout1");
        sbit(1'b1); sbit(1'b1); sbit(1'b0);
        q_m.push_back(4'b1100);
        dout_ready = 1'b1; sbit(1'b0); dout_ready = 1'b0;
        chk_b("t4_valid", valid_m, 1'b1);
        chk_b("t4_ovr", ovr_m, 1'b0);
        pop_m("t4_dout2");

        // 5: clear mid-word, bit presented with clear discarded
        do_reset();
        sbit(1'b1); sbit(1'b1);
        chk_b("t5_busy_pre", busy_m, 1'b1);
        clear = 1'b1; sbit(1'b1); clear = 1'b0;
        chk_b("t5_busy_clr", busy_m, 1'b0);
        sbit(1'b1); sbit(1'b0); sbit(1'b1);
        chk_b("t5_valid3", valid_m, 1'b0);
        q_m.push_back(4'b1010);
        sbit(1'b0);
        chk_b("t5_valid", valid_m, 1'b1);
        pop_m("t5_dout");

        // 6: async reset mid-word with a word held
        do_reset();
        send4(4'b0110);
        sbit(1'b1); sbit(1'b1); sbit(1'b1);
        chk_b("t6_valid_pre", valid_m, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk_w("t6_dout_rst", dout_m, 4'b0000);
        chk_b("t6_valid_rst", valid_m, 1'b0);
        chk_b("t6_busy_rst", busy_m, 1'b0);
        chk_b("t6_ovr_rst", ovr_m, 1'b0);
        #1 rst = 1'b1;
        sbit(1'b1); sbit(1'b0); sbit(1'b0);
        chk_b("t6_valid3", valid_m, 1'b0);
        q_m.push_back(4'b1001);
        sbit(1'b1);
        chk_b("t6_valid", valid_m, 1'b1);
        pop_m("t6_dout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
